// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: FSM states,
// operation-kind encoding and the default datapath width.
package hilo_muldiv_unit_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_e;

endpackage

// File: rtl/hilo_iter_core.sv
// Counter-driven iterative datapath: shift-add multiply and restoring divide
// sharing one 2*WIDTH accumulator ({hi, lo} for mul, {rem, quo} for div).
module hilo_iter_core
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             op_kind,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             last,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  logic               op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   b_q, b_d;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;
  logic               div_bit;
  logic [2*WIDTH-1:0] step_val;

  always_comb begin
    // Multiply: add multiplicand into the upper half when the current
    // multiplier bit (acc[0]) is set, then shift the whole product right.
    sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    // Divide: shift the next dividend bit into the partial remainder.
    shifted  = acc_q[2*WIDTH-1:WIDTH-1];
    diff     = shifted - {1'b0, b_q};
    div_bit  = (shifted >= {1'b0, b_q});
    if (op_q == OP_MUL) begin
      step_val = {sum, acc_q[WIDTH-1:1]};
    end else begin
      step_val = {(div_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0]),
                  acc_q[WIDTH-2:0], div_bit};
    end

    op_d  = op_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    b_d   = b_q;
    if (load) begin
      op_d  = op_kind;
      cnt_d = '0;
      acc_d = {{WIDTH{1'b0}}, (op_kind == OP_DIV) ? op_a : op_b};
      b_d   = (op_kind == OP_DIV) ? op_b : op_a;
    end else if (step) begin
      cnt_d = cnt_q + 1'b1;
      acc_d = step_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= 1'b0;
      cnt_q <= '0;
      acc_q <= '0;
      b_q   <= '0;
    end else begin
      op_q  <= op_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      b_q   <= b_d;
    end
  end

  // Result of the step being taken this cycle, so the final step can commit.
  assign res_hi = step_val[2*WIDTH-1:WIDTH];
  assign res_lo = step_val[WIDTH-1:0];
  assign last   = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register pair with iterative unsigned multu/divu, mthi/mtlo writes,
// flush and a busy/done interface to the hazard logic.
module hilo_muldiv_unit
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state
);

  // Handshake: start_* is a one-cycle strobe accepted only when not RUN and
  // not flushed; busy is high exactly while RUN; done pulses one cycle when
  // the new HI/LO first become visible.

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             load, step, commit, last;
  logic             op_kind;
  logic [WIDTH-1:0] res_hi, res_lo;

  hilo_iter_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .step    (step),
    .op_kind (op_kind),
    .op_a    (op_a),
    .op_b    (op_b),
    .last    (last),
    .res_hi  (res_hi),
    .res_lo  (res_lo)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    commit  = 1'b0;
    op_kind = start_mult ? OP_MUL : OP_DIV;

    case (state_q)
      ST_RUN: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          step = 1'b1;
          if (last) begin
            commit  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      default: begin
        if ((start_mult || start_div) && !flush) begin
          load    = 1'b1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase

    // A direct write alongside an accepted start lands now; commit overwrites later.
    hi_d = hi_q;
    lo_d = lo_q;
    if (state_q != ST_RUN) begin
      if (hi_we) hi_d = wdata;
      if (lo_we) lo_d = wdata;
    end
    if (commit) begin
      hi_d = res_hi;
      lo_d = res_lo;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign dbg_state = state_q;

endmodule
